// File: rtl/fq_pkg.sv
// Shared types and header field layout for the fair-queue ingress stage.
package fq_pkg;

    localparam int unsigned HDR_LEN_LSB  = 0;
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_FLOW_LSB = 8;

    typedef logic [63:0] word_t;
    // Widest flow id field a header can carry; designs use the low NUM_IN_LOG2 bits.
    typedef logic [7:0]  flow_id_t;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } ingress_state_t;

    function automatic logic [7:0] hdr_len(word_t w);
        return w[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/fq_flow_enqueue_if.sv
// Ingress word stream plus the per-flow show-ahead FIFO view seen by the scheduler.
interface fq_flow_enqueue_if #(
    parameter int unsigned NUM_IN_LOG2 = 3
) ();
    localparam int unsigned NumFlows = 2 ** NUM_IN_LOG2;

    logic           in_valid;
    logic           in_ready;
    fq_pkg::word_t  in_data;
    logic           fifo_empty [NumFlows];
    fq_pkg::word_t  fifo_data  [NumFlows];
    logic           fifo_rdreq [NumFlows];

    modport master (
        output in_valid, in_data, fifo_rdreq,
        input  in_ready, fifo_empty, fifo_data
    );

    modport slave (
        input  in_valid, in_data, fifo_rdreq,
        output in_ready, fifo_empty, fifo_data
    );

endinterface

// File: rtl/fq_flow_fifo.sv
// One per-flow FIFO: write, commit and read pointers over a single RAM with a show-ahead head.
module fq_flow_fifo
    import fq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  word_t                    wr_data,
    input  logic                     commit_en,
    output logic [FIFO_DEPTH_LOG2:0] free,
    output logic                     empty,
    output word_t                    head,
    input  logic                     rdreq
);
    localparam int unsigned AW    = FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;

    typedef logic [PW-1:0] ptr_t;

    ptr_t  wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic  empty_q, empty_d;
    word_t head_q, head_d;
    logic  pop;
    word_t ram [DEPTH];

    always_comb begin
        pop      = rdreq && (commit_q != rd_q);
        wr_d     = wr_en ? wr_q + PW'(1) : wr_q;
        commit_d = commit_en ? wr_d : commit_q;
        rd_d     = pop ? rd_q + PW'(1) : rd_q;
        empty_d  = (commit_d == rd_d);
        // Bypass a write landing on the next head slot; the RAM read would return stale data.
        head_d   = ram[rd_d[AW-1:0]];
        if (wr_en && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_q[AW-1:0]] <= wr_data;
        end
    end

    assign free  = PW'(DEPTH) - (wr_q - rd_q);
    assign empty = empty_q;
    assign head  = head_q;

endmodule

// File: rtl/fq_flow_enqueue.sv
// Ingress stage: steers whole length-framed packets into per-flow FIFOs, dropping what won't fit.
// Define FQ_DROP_CNT_EN to add the saturating drop_count output.
module fq_flow_enqueue
    import fq_pkg::*;
#(
    parameter int unsigned NUM_IN_LOG2     = 3,
    parameter int unsigned FIFO_DEPTH_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fq_flow_enqueue_if.slave        bus
`ifdef FQ_DROP_CNT_EN
    ,
    output logic [31:0]             drop_count
`endif
);
    localparam int unsigned NF = 2 ** NUM_IN_LOG2;
    localparam int unsigned PW = FIFO_DEPTH_LOG2 + 1;

    ingress_state_t         state_q, state_d;
    logic [7:0]             rem_q, rem_d;
    logic [NUM_IN_LOG2-1:0] flow_q, flow_d;
    logic                   in_ready_q, in_ready_d;

    logic                   accept;
    logic [NUM_IN_LOG2-1:0] hdr_flow;
    logic [7:0]             hdr_len_w;
    logic                   hdr_ok;
    logic                   wr_sel, commit_sel;
    logic [NUM_IN_LOG2-1:0] wr_flow;
    logic [NF-1:0]          wr_en, commit_en;
    logic [PW-1:0]          free [NF];

    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        hdr_flow   = bus.in_data[HDR_FLOW_LSB +: NUM_IN_LOG2];
        hdr_len_w  = hdr_len(bus.in_data);
        // Same-cycle pops are not credited, so admission can only under-estimate space.
        hdr_ok     = (hdr_len_w != 8'd0) && (free[hdr_flow] >= PW'(hdr_len_w));
        in_ready_d = 1'b1;
        state_d    = state_q;
        rem_d      = rem_q;
        flow_d     = flow_q;
        wr_sel     = 1'b0;
        commit_sel = 1'b0;
        wr_flow    = flow_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        wr_sel  = 1'b1;
                        wr_flow = hdr_flow;
                        if (hdr_len_w == 8'd1) begin
                            commit_sel = 1'b1;
                        end else begin
                            rem_d   = hdr_len_w - 8'd1;
                            flow_d  = hdr_flow;
                            state_d = FWD;
                        end
                    end else if (hdr_len_w > 8'd1) begin
                        rem_d   = hdr_len_w - 8'd1;
                        state_d = DROP;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    wr_sel = 1'b1;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        commit_sel = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned i = 0; i < NF; i++) begin
            wr_en[i]     = wr_sel && (wr_flow == NUM_IN_LOG2'(i));
            commit_en[i] = commit_sel && (wr_flow == NUM_IN_LOG2'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            flow_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            flow_q     <= flow_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready = in_ready_q;

    for (genvar g = 0; g < NF; g++) begin : g_flow
        fq_flow_fifo #(
            .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[g]),
            .wr_data  (bus.in_data),
            .commit_en(commit_en[g]),
            .free     (free[g]),
            .empty    (bus.fifo_empty[g]),
            .head     (bus.fifo_data[g]),
            .rdreq    (bus.fifo_rdreq[g])
        );
    end

`ifdef FQ_DROP_CNT_EN
    logic        drop_hdr;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_hdr   = (state_q == IDLE) && accept && !hdr_ok;
        drop_cnt_d = drop_cnt_q;
        if (drop_hdr && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
